// File: rtl/rotate_restore_pipe.sv
// Pipelined inverse rotator: undoes a rotate of in_amt in direction in_dir,
// one stage per amount bit, with valid/ready flow control and bubble collapsing.
module rotate_restore_pipe #(
  parameter int N = 4,
  localparam int W = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [N-1:0] in_amt,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [N-1:0] out_amt,
  output logic         out_dir
);

  logic [N-1:0]          v_reg;
  logic [N-1:0][W-1:0]   data_reg;
  logic [N-1:0][N-1:0]   amt_reg;
  logic [N-1:0]          dir_reg;

  logic [N-1:0]          adv;
  logic [N-1:0]          src_valid;
  logic [N-1:0][W-1:0]   src_data;
  logic [N-1:0][N-1:0]   src_amt;
  logic [N-1:0]          src_dir;
  logic [N-1:0][W-1:0]   data_next;

  // A stage may move when it is empty or the stage after it moves; this is
  // what collapses bubbles ahead of a stall.
  always_comb begin
    adv = '0;
    adv[N-1] = !v_reg[N-1] || out_ready;
    for (int s = N - 2; s >= 0; s--) begin
      adv[s] = !v_reg[s] || adv[s+1];
    end
  end

  always_comb begin
    src_valid = '0;
    src_data  = '0;
    src_amt   = '0;
    src_dir   = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_amt[0]   = in_amt;
    src_dir[0]   = in_dir;
    for (int s = 1; s < N; s++) begin
      src_valid[s] = v_reg[s-1];
      src_data[s]  = data_reg[s-1];
      src_amt[s]   = amt_reg[s-1];
      src_dir[s]   = dir_reg[s-1];
    end
  end

  // Stage gi undoes the 2^gi component of the original rotation, so it turns
  // the opposite way to src_dir.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      localparam int K = 1 << gi;
      logic [W-1:0] rot_right;
      logic [W-1:0] rot_left;
      assign rot_right = (src_data[gi] >> K) | (src_data[gi] << (W - K));
      assign rot_left  = (src_data[gi] << K) | (src_data[gi] >> (W - K));
      assign data_next[gi] = !src_amt[gi][gi] ? src_data[gi] :
                             (src_dir[gi] ? rot_right : rot_left);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg    <= '0;
      data_reg <= '0;
      amt_reg  <= '0;
      dir_reg  <= '0;
    end else begin
      for (int s = 0; s < N; s++) begin
        if (adv[s]) begin
          v_reg[s]    <= src_valid[s];
          data_reg[s] <= data_next[s];
          amt_reg[s]  <= src_amt[s];
          dir_reg[s]  <= src_dir[s];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_reg[N-1];
  assign out_data  = data_reg[N-1];
  assign out_amt   = amt_reg[N-1];
  assign out_dir   = dir_reg[N-1];

endmodule

// File: tb/tb_rotate_restore_pipe.sv
// Bench for rotate_restore_pipe: directed vectors, backpressure, random traffic
// against a rotation scoreboard, and mid-flight asynchronous reset.
module tb_rotate_restore_pipe;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [N-1:0] in_amt = '0;
  logic         in_dir = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [N-1:0] out_amt;
  logic         out_dir;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] amt;
    logic         dir;
  } item_t;

  item_t exp_q[$];
  int    out_count = 0;
  logic  hold_pend = 1'b0;
  item_t held;

  always #5 clk = ~clk;

  rotate_restore_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_amt   (out_amt),
    .out_dir   (out_dir)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Original word: undo a left rotate by rotating right a, undo a right rotate
  // by rotating right W-a; a right rotate is the low half of {d,d} >> r.
  function automatic logic [W-1:0] restore(input logic [W-1:0] d, input logic [N-1:0] a,
                                           input logic was_left);
    logic [2*W-1:0] dd;
    int r;
    r  = was_left ? int'(a) : (W - int'(a)) % W;
    dd = {d, d} >> r;
    return dd[W-1:0];
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pend) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(held.data));
          check("hold_amt", 32'(out_amt), 32'(held.amt));
          check("hold_dir", 32'(out_dir), 32'(held.dir));
        end
        if (in_valid && in_ready)
          exp_q.push_back('{restore(in_data, in_amt, in_dir), in_amt, in_dir});
        if (out_valid && out_ready) begin
          out_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(out_data), 32'(e.data));
            check("sb_amt", 32'(out_amt), 32'(e.amt));
            check("sb_dir", 32'(out_dir), 32'(e.dir));
          end
        end
        hold_pend = out_valid && !out_ready;
        held = '{out_data, out_amt, out_dir};
      end
    end
  end

  task automatic directed(input string tag, input logic [W-1:0] d, input logic [N-1:0] a,
                          input logic dr, input logic [W-1:0] exp);
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_dir    = dr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("[TB] %s: data=%h amt=%0d dir=%0b -> out=%h after %0d cycles", tag, d, a, dr, out_data, cyc);
    check({tag, "_lat"}, 32'(cyc), 32'd4);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    check({tag, "_amt"}, 32'(out_amt), 32'(a));
    check({tag, "_dir"}, 32'(out_dir), 32'(dr));
  endtask

  task automatic set_bp_word(input int i);
    in_data = 16'(i);
    in_amt  = 4'(i);
    in_dir  = 1'(i & 1);
  endtask

  initial begin
    int idx, acc, base, sent, cyc;
    logic take;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_amt", 32'(out_amt), 32'd0);
    check("rst_out_dir", 32'(out_dir), 32'd0);
    rst_n = 1'b1;

    directed("rot_r1", 16'h8001, 4'd1, 1'b1, 16'hC000);
    directed("rot_l4", 16'h0003, 4'd4, 1'b0, 16'h0030);
    directed("rt_2341", 16'h2341, 4'd4, 1'b1, 16'h1234);
    directed("rt_fffe", 16'hFFFE, 4'd15, 1'b0, 16'h7FFF);
    directed("amt0", 16'hA5A5, 4'd0, 1'b1, 16'hA5A5);

    // Backpressure: fill with out_ready low, then release.
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 1;
    acc = 0;
    in_valid = 1'b1;
    set_bp_word(idx);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      take = in_ready;
      @(posedge clk); #1;
      if (take) begin
        acc++;
        idx++;
        set_bp_word(idx);
      end
    end
    $display("[TB] backpressure: accepted=%0d in_ready=%0b out_data=%h", acc, in_ready, out_data);
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_first", 32'(out_data), 32'h8000);
    out_ready = 1'b1;
    base = out_count;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        idx++;
        if (idx > 6) in_valid = 1'b0;
        else set_bp_word(idx);
      end
    end
    $display("[TB] backpressure drain: %0d words in 6 cycles", out_count - base);
    check("bp_drain_count", 32'(out_count - base), 32'd6);

    // Random traffic with random downstream stalls.
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        in_amt   = 4'($urandom);
        in_dir   = 1'($urandom);
      end
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    $display("[TB] random: sent=%0d cycles=%0d outstanding=%0d", sent, cyc, exp_q.size());
    check("rand_sent", 32'(sent), 32'd1000);
    check("rand_drain", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with words in flight.
    out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h1111 * (w + 1));
      in_amt   = 4'(w + 1);
      in_dir   = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    hold_pend = 1'b0;
    #1;
    $display("[TB] mid reset: out_valid=%0b out_data=%h in_ready=%0b", out_valid, out_data, in_ready);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_amt", 32'(out_amt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    directed("post_rst", 16'h0F00, 4'd8, 1'b1, 16'h000F);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
